// File: rtl/node_burst_fetch.sv
// Node fetch stage: one fixed-length Avalon-MM burst read per Avalon-ST request,
// beats packed LSB-first into a single node word on an Avalon-ST source.
module node_burst_fetch #(
    parameter int ADDR_W = 26,
    parameter int BEATS  = 6,
    parameter int CNT_W  = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         asi_fetch_data,
    input  logic                asi_fetch_channel,
    input  logic                asi_fetch_valid,
    output logic                asi_fetch_ready,
    output logic [ADDR_W-1:0]   avm_node_address,
    output logic                avm_node_read,
    output logic [5:0]          avm_node_burstcount,
    input  logic                avm_node_waitrequest,
    input  logic [15:0]         avm_node_readdata,
    input  logic                avm_node_readdatavalid,
    output logic                avm_node_write,
    output logic [15:0]         avm_node_writedata,
    output logic [16*BEATS-1:0] aso_result_data,
    output logic                aso_result_channel,
    output logic                aso_result_valid,
    input  logic                aso_result_ready,
    output logic [CNT_W-1:0]    fetch_count
);

    localparam int DATA_W = 16 * BEATS;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, COLLECT, OUTPUT} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                chan_q, chan_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                beat_take;
    logic                last_beat;

    // Reserved request bits and the byte-lane bit are deliberately dropped.
    logic unused_fetch_bits;
    assign unused_fetch_bits = ^{asi_fetch_data[31:ADDR_W], asi_fetch_data[0]};

    // Beats are only meaningful while a burst is in flight; strays elsewhere are dropped.
    assign beat_take = avm_node_readdatavalid
                    && ((state_q == ISSUE) || (state_q == COLLECT))
                    && (beat_q <= BEAT_W'(BEATS - 1));

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d   = state_q;
        addr_d    = addr_q;
        chan_d    = chan_q;
        beat_d    = beat_q;
        data_d    = data_q;
        count_d   = count_q;
        last_beat = 1'b0;

        if (beat_take) begin
            data_d[16*beat_q +: 16] = avm_node_readdata;
            beat_d                  = beat_q + BEAT_W'(1);
            last_beat               = (beat_q == BEAT_W'(BEATS - 1));
        end

        case (state_q)
            IDLE: begin
                if (asi_fetch_valid) begin
                    addr_d  = {asi_fetch_data[ADDR_W-1:1], 1'b0};
                    chan_d  = asi_fetch_channel;
                    beat_d  = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Early data may land in the acceptance cycle, so the exit honours last_beat.
                if (!avm_node_waitrequest) begin
                    state_d = last_beat ? OUTPUT : COLLECT;
                end
            end
            COLLECT: begin
                if (last_beat) begin
                    state_d = OUTPUT;
                end
            end
            OUTPUT: begin
                if (aso_result_ready) begin
                    count_d = count_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            chan_q  <= 1'b0;
            beat_q  <= '0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            chan_q  <= chan_d;
            beat_q  <= beat_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign asi_fetch_ready     = (state_q == IDLE);
    assign avm_node_read       = (state_q == ISSUE);
    assign avm_node_address    = addr_q;
    assign avm_node_burstcount = avm_node_read ? 6'(BEATS) : 6'd0;
    assign avm_node_write      = 1'b0;
    assign avm_node_writedata  = 16'd0;
    assign aso_result_data     = data_q;
    assign aso_result_channel  = chan_q;
    assign aso_result_valid    = (state_q == OUTPUT);
    assign fetch_count         = count_q;

endmodule

// File: tb/tb_node_burst_fetch.sv
// Directed bench for node_burst_fetch: drives requests and a node-bus slave on the
// falling edge, checks outputs on the falling edge against hand-computed values.
module tb_node_burst_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] asi_fetch_data;
    logic        asi_fetch_channel;
    logic        asi_fetch_valid;
    logic        asi_fetch_ready;
    logic [25:0] avm_node_address;
    logic        avm_node_read;
    logic [5:0]  avm_node_burstcount;
    logic        avm_node_waitrequest;
    logic [15:0] avm_node_readdata;
    logic        avm_node_readdatavalid;
    logic        avm_node_write;
    logic [15:0] avm_node_writedata;
    logic [95:0] aso_result_data;
    logic        aso_result_channel;
    logic        aso_result_valid;
    logic        aso_result_ready;
    logic [31:0] fetch_count;

    int n_checks = 0;
    int n_errors = 0;
    int cmd_cnt  = 0;
    int exp_cmd  = 0;

    node_burst_fetch dut (
        .clk                    (clk),
        .reset                  (reset),
        .asi_fetch_data         (asi_fetch_data),
        .asi_fetch_channel      (asi_fetch_channel),
        .asi_fetch_valid        (asi_fetch_valid),
        .asi_fetch_ready        (asi_fetch_ready),
        .avm_node_address       (avm_node_address),
        .avm_node_read          (avm_node_read),
        .avm_node_burstcount    (avm_node_burstcount),
        .avm_node_waitrequest   (avm_node_waitrequest),
        .avm_node_readdata      (avm_node_readdata),
        .avm_node_readdatavalid (avm_node_readdatavalid),
        .avm_node_write         (avm_node_write),
        .avm_node_writedata     (avm_node_writedata),
        .aso_result_data        (aso_result_data),
        .aso_result_channel     (aso_result_channel),
        .aso_result_valid       (aso_result_valid),
        .aso_result_ready       (aso_result_ready),
        .fetch_count            (fetch_count)
    );

    always #5 clk = ~clk;

    // Counts commands the slave accepts.
    always @(posedge clk) begin
        if (avm_node_read && !avm_node_waitrequest) cmd_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_req(input logic [31:0] a, input logic ch);
        asi_fetch_data    = a;
        asi_fetch_channel = ch;
        asi_fetch_valid   = 1'b1;
        for (int n = 0; n < 64 && !asi_fetch_ready; n++) @(negedge clk);
        check("req_ready", asi_fetch_ready, 1'b1);
        @(negedge clk);
        asi_fetch_valid = 1'b0;
    endtask

    task automatic issue_phase(input int stall, input logic [25:0] exp_addr);
        for (int i = 0; i <= stall; i++) begin
            avm_node_waitrequest = (i < stall);
            check("cmd_read", avm_node_read, 1'b1);
            check("cmd_addr", avm_node_address, exp_addr);
            check("cmd_burst", avm_node_burstcount, 6'd6);
            check("issue_busy", asi_fetch_ready, 1'b0);
            @(negedge clk);
        end
        avm_node_waitrequest = 1'b0;
        check("read_drop", avm_node_read, 1'b0);
        exp_cmd++;
        check("cmd_count", cmd_cnt, exp_cmd);
    endtask

    task automatic send_beats(input logic [95:0] w, input int gap, input int n);
        for (int i = 0; i < n; i++) begin
            avm_node_readdatavalid = 1'b0;
            repeat (gap) @(negedge clk);
            avm_node_readdatavalid = 1'b1;
            avm_node_readdata      = w[16*i +: 16];
            @(negedge clk);
        end
        avm_node_readdatavalid = 1'b0;
    endtask

    task automatic output_phase(input logic [95:0] w, input logic ch, input int hold,
                                input logic [31:0] exp_cnt);
        for (int i = 0; i <= hold; i++) begin
            check("res_valid", aso_result_valid, 1'b1);
            check("res_data", aso_result_data, w);
            check("res_chan", aso_result_channel, ch);
            check("out_busy", asi_fetch_ready, 1'b0);
            aso_result_ready = (i == hold);
            @(negedge clk);
        end
        aso_result_ready = 1'b0;
        check("valid_drop", aso_result_valid, 1'b0);
        check("ready_back", asi_fetch_ready, 1'b1);
        check("fetch_count", fetch_count, exp_cnt);
    endtask

    localparam logic [95:0] W1 = 96'h6666_5555_4444_3333_2222_1111;
    localparam logic [95:0] W2 = 96'hA5A5_0F0F_F0F0_1234_5678_9ABC;
    localparam logic [95:0] W3 = 96'hDEAD_BEEF_CAFE_F00D_0001_8000;
    localparam logic [95:0] W4 = 96'h0102_0304_0506_0708_090A_0B0C;
    localparam logic [95:0] W5 = 96'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA;
    localparam logic [95:0] W6 = 96'h1357_9BDF_2468_ACE0_FEDC_BA98;
    localparam logic [95:0] W7 = 96'h7777_0000_7777_0000_7777_0000;

    initial begin
        reset                  = 1'b0;
        asi_fetch_data         = '0;
        asi_fetch_channel      = 1'b0;
        asi_fetch_valid        = 1'b0;
        avm_node_waitrequest   = 1'b0;
        avm_node_readdata      = '0;
        avm_node_readdatavalid = 1'b0;
        aso_result_ready       = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_ready", asi_fetch_ready, 1'b1);
        check("rst_read", avm_node_read, 1'b0);
        check("rst_burst", avm_node_burstcount, 6'd0);
        check("rst_addr", avm_node_address, 26'd0);
        check("rst_valid", aso_result_valid, 1'b0);
        check("rst_data", aso_result_data, 96'd0);
        check("rst_count", fetch_count, 32'd0);
        check("tie_write", {avm_node_write, avm_node_writedata}, 17'd0);
        reset = 1'b1;
        @(negedge clk);

        // Single fetch, no stalls.
        send_req(32'h0000_0100, 1'b1);
        issue_phase(0, 26'h000_0100);
        send_beats(W1, 0, 6);
        output_phase(W1, 1'b1, 0, 32'd1);

        // Slave stalls the command for 4 cycles.
        send_req(32'h0000_0300, 1'b0);
        issue_phase(4, 26'h000_0300);
        send_beats(W2, 0, 6);
        output_phase(W2, 1'b0, 0, 32'd2);

        // Beats every 3rd cycle, downstream stalls 5 cycles.
        send_req(32'h0000_1234, 1'b1);
        issue_phase(0, 26'h000_1234);
        send_beats(W3, 2, 6);
        output_phase(W3, 1'b1, 5, 32'd3);

        // Back-to-back requests with the source valid continuously.
        asi_fetch_data    = 32'h0000_0201;
        asi_fetch_channel = 1'b0;
        asi_fetch_valid   = 1'b1;
        check("b2b_ready", asi_fetch_ready, 1'b1);
        @(negedge clk);
        asi_fetch_data    = 32'h0000_0400;
        asi_fetch_channel = 1'b1;
        issue_phase(0, 26'h000_0200);
        send_beats(W4, 0, 6);
        output_phase(W4, 1'b0, 1, 32'd4);
        @(negedge clk);
        asi_fetch_valid = 1'b0;
        issue_phase(0, 26'h000_0400);
        send_beats(W5, 0, 6);
        output_phase(W5, 1'b1, 0, 32'd5);

        // Reset after the 3rd beat, then stale beats arrive in IDLE.
        send_req(32'h0000_0500, 1'b1);
        issue_phase(0, 26'h000_0500);
        send_beats(W6, 0, 3);
        reset = 1'b0;
        #1;
        check("arst_ready", asi_fetch_ready, 1'b1);
        check("arst_count", fetch_count, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        send_beats(W6, 0, 3);
        check("stale_valid", aso_result_valid, 1'b0);
        check("stale_read", avm_node_read, 1'b0);
        check("stale_data", aso_result_data, 96'd0);
        check("stale_count", fetch_count, 32'd0);
        check("stale_ready", asi_fetch_ready, 1'b1);

        // Next fetch after reset; reserved bits set must not reach the address.
        send_req(32'hFC00_0601, 1'b0);
        issue_phase(0, 26'h000_0600);
        send_beats(W6, 0, 6);
        output_phase(W6, 1'b0, 0, 32'd1);

        // Counter wraps from all-ones.
        force dut.count_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.count_q;
        @(negedge clk);
        check("preload", fetch_count, 32'hFFFF_FFFF);
        send_req(32'h0000_0700, 1'b1);
        issue_phase(0, 26'h000_0700);
        send_beats(W7, 0, 6);
        output_phase(W7, 1'b1, 0, 32'h0000_0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/node_burst_fetch.md
Name: node_burst_fetch

Overview:
- Fetch stage directly upstream of the result stream consumed by CoPartial (`asi_result_*`).
- Accepts single-node fetch requests on an Avalon-ST sink.
- Issues one fixed-length Avalon-MM burst read per request on the 16-bit node bus.
- Packs the returned beats into one 96-bit node word and presents it, with the request's channel bit, on an Avalon-ST source.

Parameters:
- ADDR_W, 26, node bus address width.
- BEATS, 6, 16-bit beats per node; the result width is 16*BEATS.
- CNT_W, 32, width of the completed-fetch counter.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- asi_fetch_data  in  32  [25:0] byte address of the node; [31:26] reserved, ignored.
- asi_fetch_channel  in  1  channel tag, carried to the output.
- asi_fetch_valid  in  1  request valid.
- asi_fetch_ready  out  1  request accepted when valid && ready.
- avm_node_address  out  ADDR_W  burst start address.
- avm_node_read  out  1  read command.
- avm_node_burstcount  out  6  burst length.
- avm_node_waitrequest  in  1  slave stall.
- avm_node_readdata  in  16  returned beat.
- avm_node_readdatavalid  in  1  beat valid.
- avm_node_write  out  1  tied 0.
- avm_node_writedata  out  16  tied 0.
- aso_result_data  out  16*BEATS  packed node.
- aso_result_channel  out  1  channel tag.
- aso_result_valid  out  1  result valid.
- aso_result_ready  in  1  downstream ready.
- fetch_count  out  CNT_W  number of results delivered.

Behaviour:
- Reset values: all outputs and registers are 0. State is IDLE, except asi_fetch_ready=1 while in IDLE.
- FSM states: IDLE, ISSUE, COLLECT, OUTPUT.
- IDLE:
  - asi_fetch_ready=1.
  - On valid && ready: latch address with bit0 forced 0, latch the channel, clear the beat counter, go to ISSUE.
- ISSUE:
  - Drive avm_node_read=1, address=latched, burstcount=BEATS.
  - While avm_node_waitrequest=1, hold all command signals stable.
  - In the first cycle with waitrequest=0, the command is accepted: deassert read on the next cycle and go to COLLECT.
  - A readdatavalid arriving in the same cycle as acceptance is captured; the interconnect can return data early.
- COLLECT:
  - Each readdatavalid writes readdata into slice [16*k+15:16*k], where k is the beat counter, then increments k.
  - When beat BEATS-1 is captured, go to OUTPUT next cycle.
  - readdatavalid in any state other than ISSUE or COLLECT is ignored. This is an error case with no side effect.
- OUTPUT:
  - aso_result_valid=1; data and channel held stable until the transfer completes.
  - On aso_result_ready=1: increment fetch_count (wraps at 2^CNT_W, no saturation), deassert valid, go to IDLE.
- asi_fetch_ready=0 in ISSUE, COLLECT and OUTPUT. At most one fetch is outstanding.
- Minimum request-to-request spacing: 1 (issue) + BEATS + 1 (output) + 1 (idle) cycles when there are no stalls.
- Latency: result valid 1 cycle after the last beat is captured.
- Beat order: first beat goes to the least significant slice.
- Reset asserted mid-burst: everything clears immediately and the FSM returns to IDLE.
  - Beats still in flight after reset release are ignored in IDLE.
  - The node bus slave is reset together with this block.
- Reserved bits [31:26] never affect the address.

Test Plan:
- Single fetch, no stalls: request addr 0x0000100, channel 1; beats 0x1111, 0x2222, 0x3333, 0x4444, 0x5555, 0x6666 on consecutive cycles.
  -> burstcount=6, address=0x0000100.
  -> result 0x666655554444333322221111, channel 1, fetch_count=1.
- waitrequest held high for 4 cycles in ISSUE -> read, address and burstcount stable for all 5 cycles; exactly one command accepted.
- Gapped beats (valid every 3rd cycle) and downstream ready low for 5 cycles.
  -> data and valid held stable; asi_fetch_ready stays 0 until 1 cycle after the handshake.
- Back-to-back requests with the source valid continuously: addresses 0x0000201 and 0x0000400, channels 0 and 1.
  -> first request issues at 0x0000200 (bit0 cleared); second is accepted only after the first result is consumed.
  -> channels are delivered in order.
- Reset pulled low after the 3rd beat, then released; 3 stale beats arrive in IDLE.
  -> no aso_result_valid; fetch_count=0.
  -> the next normal fetch returns correct data.
- fetch_count preloaded near wrap via force at 0xFFFFFFFF, then one fetch -> count wraps to 0x00000000.
